// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: a word-addressed ROM/RAM with a fixed, pipelined read latency,
// a flush/invalidate accept blackout, and a side port for preloading programs.
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          LATENCY      = 2,
  parameter int          FLUSH_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_rd_i,
  input  logic [31:0] req_pc_i,
  input  logic        req_flush_i,
  input  logic        req_invalidate_i,
  output logic        accept_o,
  output logic        valid_o,
  output logic        error_o,
  output logic [31:0] inst_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam int          CW   = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [CW-1:0] flush_cnt;
  logic [31:0]   off, load_off, fetch_data;
  logic          fetch_err, load_ok, take;

  logic [LATENCY:1] vld_pipe;
  logic [LATENCY:1] err_pipe;
  logic [31:0]      dat_pipe [LATENCY:1];

  assign accept_o = rst_ni && !load_we_i && (flush_cnt == '0);
  assign take     = req_rd_i && accept_o;

  // Unsigned wrap makes pc < BASE land far above SPAN; the explicit compare is kept for clarity.
  assign off        = req_pc_i - BASE_ADDR;
  assign fetch_err  = (req_pc_i[1:0] != 2'b00) || (req_pc_i < BASE_ADDR) || (off >= SPAN);
  assign fetch_data = fetch_err ? '0 : mem[off[AW+1:2]];

  assign load_off = load_addr_i - BASE_ADDR;
  assign load_ok  = (load_addr_i[1:0] == 2'b00) && (load_addr_i >= BASE_ADDR) && (load_off < SPAN);

  always_ff @(posedge clk_i) begin
    if (load_we_i && load_ok) mem[load_off[AW+1:2]] <= load_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              flush_cnt <= '0;
    else if (req_flush_i || req_invalidate_i) flush_cnt <= CW'(FLUSH_CYCLES);
    else if (flush_cnt != '0)                 flush_cnt <= flush_cnt - 1'b1;
  end

  // Data stages only advance with a valid token, so the last stage holds the previous response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= take;
      if (take) begin
        err_pipe[1] <= fetch_err;
        dat_pipe[1] <= fetch_data;
      end
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          err_pipe[i] <= err_pipe[i-1];
          dat_pipe[i] <= dat_pipe[i-1];
        end
      end
    end
  end

  assign valid_o = vld_pipe[LATENCY];
  assign error_o = vld_pipe[LATENCY] & err_pipe[LATENCY];
  assign inst_o  = dat_pipe[LATENCY];

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: expected responses are queued at accept time
// and checked (value and arrival cycle) by a negedge monitor.
module tb_imem_fetch_responder;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          FLUSH = 4;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_rd = 1'b0, req_flush = 1'b0, req_inv = 1'b0, load_we = 1'b0;
  logic [31:0] req_pc = '0, load_addr = '0, load_data = '0;
  logic        accept, valid, error;
  logic [31:0] inst;

  int          total = 0, bad = 0, cyc = 0, fl_cnt = 0;
  exp_t        exp_q[$];
  logic [31:0] mdl [int];
  logic [31:0] last_inst = '0;

  imem_fetch_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_rd_i(req_rd), .req_pc_i(req_pc), .req_flush_i(req_flush), .req_invalidate_i(req_inv),
    .accept_o(accept), .valid_o(valid), .error_o(error), .inst_o(inst),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (a[1:0] == 2'b00) && (a >= BASE) && (o < 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_inst = '0;
    end else if (valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_valid cyc=%0d err=%b inst=%h", cyc, error, inst);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.due || error !== e.err || inst !== e.inst) begin
          bad++;
          $display("FAIL response cyc=%0d err=%b inst=%h, expected cyc=%0d err=%b inst=%h",
                   cyc, error, inst, e.due, e.err, e.inst);
        end
      end
      last_inst = inst;
    end else begin
      total++;
      if (error !== 1'b0 || inst !== last_inst) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d err=%b inst=%h, expected err=0 inst=%h",
                 cyc, error, inst, last_inst);
      end
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_response cyc=%0d expected at cyc=%0d inst=%h",
                 cyc, exp_q[0].due, exp_q[0].inst);
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus: checks accept_o against the bench's own flush/load model.
  task automatic drive(input logic rd, input logic [31:0] pc, input logic fl, input logic inv,
                       input logic we, input logic [31:0] la, input logic [31:0] ld);
    logic exp_acc;
    exp_t e;
    @(posedge clk); #1;
    req_rd = rd; req_pc = pc; req_flush = fl; req_inv = inv;
    load_we = we; load_addr = la; load_data = ld;
    #1;
    exp_acc = !we && (fl_cnt == 0);
    total++;
    if (accept !== exp_acc) begin
      bad++;
      $display("FAIL accept cyc=%0d got=%b expected=%b", cyc, accept, exp_acc);
    end
    if (rd && exp_acc) begin
      e.due  = cyc + LAT;
      e.err  = !addr_ok(pc);
      e.inst = e.err ? 32'h0 : mdl[widx(pc)];
      exp_q.push_back(e);
    end
    if (we && addr_ok(la)) mdl[widx(la)] = ld;
    if (fl || inv) fl_cnt = FLUSH;
    else if (fl_cnt > 0) fl_cnt--;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic fetch(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || error !== 1'b0 || inst !== 32'h0 || accept !== 1'b0) begin
      bad++;
      $display("FAIL reset_state valid=%b err=%b inst=%h accept=%b, expected all 0",
               valid, error, inst, accept);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fl_cnt = 0;
  endtask

  task automatic test_fetch;
    load(32'h0, 32'h0000_0013);
    load(32'h4, 32'h1234_5678);
    fetch(32'h0);
    fetch(32'h4);
    idle(3);
  endtask

  task automatic test_errors;
    load(32'hFFC, 32'hCAFE_F00D);
    fetch(32'h6);
    fetch(32'h1000);
    fetch(32'hFFC);
    fetch(32'hFFFF_FFFC);
    fetch(32'h1);
    idle(3);
  endtask

  task automatic test_flush;
    load(32'h8, 32'hA5A5_0008);
    fetch(32'h0);
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, '0, '0);
    repeat (5) fetch(32'h8);
    idle(3);
    // Invalidate, then re-assert while counting, then both inputs together.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    fetch(32'h4);
    drive(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, '0, '0);
    repeat (5) fetch(32'h4);
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, '0, '0);
    repeat (5) fetch(32'h8);
    idle(3);
  endtask

  task automatic test_load_block;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2, 32'h1111_1111);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2222_2222);
    fetch(32'h0);
    idle(3);
  endtask

  task automatic test_back_to_back;
    logic [31:0] pc;
    for (int i = 0; i < 8; i++) load(32'(i * 4), $urandom | 32'h1);
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 5))
        0:       pc = 32'(4 * $urandom_range(0, 7)) | 32'($urandom_range(1, 3));
        1:       pc = 32'h1000 + 32'(4 * $urandom_range(0, 100));
        default: pc = 32'(4 * $urandom_range(0, 7));
      endcase
      fetch(pc);
    end
    idle(4);
  endtask

  task automatic test_reset_midflight;
    fetch(32'h4);
    idle(3);
    fetch(32'h0);
    @(posedge clk); #1;
    req_rd = 1'b0; load_we = 1'b0; req_flush = 1'b0; req_inv = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    fl_cnt = 0;
    #1;
    total++;
    if (valid !== 1'b0 || error !== 1'b0 || inst !== 32'h0 || accept !== 1'b0) begin
      bad++;
      $display("FAIL midflight_reset valid=%b err=%b inst=%h accept=%b, expected all 0",
               valid, error, inst, accept);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    fetch(32'h0);
    fetch(32'h4);
    idle(3);
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_errors;
    test_flush;
    test_load_block;
    test_back_to_back;
    test_reset_midflight;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
